// File: rtl/bus_pkg.sv
// Shared types and encodings for the two-master / three-slave system bus.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_S1   = 2'b01;
    localparam logic [1:0] SEL_S2   = 2'b10;
    localparam logic [1:0] SEL_S3   = 2'b11;

    localparam logic [1:0] BG_NONE = 2'b00;
    localparam logic [1:0] BG_M1   = 2'b01;
    localparam logic [1:0] BG_M2   = 2'b10;

    localparam logic [2:0] SG_NONE = 3'b000;
    localparam logic [2:0] SG_S1   = 3'b001;
    localparam logic [2:0] SG_S2   = 3'b010;
    localparam logic [2:0] SG_S3   = 3'b100;

    function automatic logic [2:0] sel_to_sg(input logic [1:0] sel);
        case (sel)
            SEL_S1:  return SG_S1;
            SEL_S2:  return SG_S2;
            SEL_S3:  return SG_S3;
            default: return SG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Ownership watchdog: counts cycles while enabled, flags the last permitted cycle.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST_COUNT);

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for two bus masters with turnaround, watchdog and select checking.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic [1:0] m1_slave_select,
    input  logic [1:0] m2_slave_select,
    input  logic       m1_tx_done,
    input  logic       m2_tx_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       busy,
    output logic [1:0] bus_grant,
    output logic [2:0] slave_grant,
    output logic       timeout,
    output logic       sel_error
);

    state_t state;
    logic   last_m2;
    logic   m1_eligible;
    logic   m2_eligible;
    logic   pick_m1;
    logic   pick_m2;
    logic   owner_request;
    logic   owner_done;
    logic   owner_release;
    logic   wd_terminal;

    // last_m2 doubles as the current owner while ACTIVE, since it updates on grant.
    always_comb begin
        m1_eligible   = m1_request && (m1_slave_select != SEL_NONE);
        m2_eligible   = m2_request && (m2_slave_select != SEL_NONE);
        pick_m1       = m1_eligible && (!m2_eligible || last_m2);
        pick_m2       = m2_eligible && !pick_m1;
        owner_request = last_m2 ? m2_request : m1_request;
        owner_done    = last_m2 ? m2_tx_done : m1_tx_done;
        owner_release = owner_done || !owner_request;
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ACTIVE),
        .enable  (state == ACTIVE),
        .terminal(wd_terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_m2     <= 1'b1;
            m1_grant    <= 1'b0;
            m2_grant    <= 1'b0;
            bus_grant   <= BG_NONE;
            slave_grant <= SG_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_m1 || pick_m2) begin
                        state       <= ACTIVE;
                        last_m2     <= pick_m2;
                        m1_grant    <= pick_m1;
                        m2_grant    <= pick_m2;
                        bus_grant   <= pick_m1 ? BG_M1 : BG_M2;
                        slave_grant <= sel_to_sg(pick_m1 ? m1_slave_select : m2_slave_select);
                    end
                end
                ACTIVE: begin
                    if (owner_release || wd_terminal) begin
                        state       <= TURNAROUND;
                        m1_grant    <= 1'b0;
                        m2_grant    <= 1'b0;
                        bus_grant   <= BG_NONE;
                        slave_grant <= SG_NONE;
                    end
                end
                TURNAROUND: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    m1_grant    <= 1'b0;
                    m2_grant    <= 1'b0;
                    bus_grant   <= BG_NONE;
                    slave_grant <= SG_NONE;
                end
            endcase
        end
    end

    // A completion in the terminal cycle takes precedence over the watchdog.
    assign timeout   = !reset && (state == ACTIVE) && wd_terminal && !owner_release;
    assign sel_error = !reset && (state == IDLE) &&
                       ((m1_request && (m1_slave_select == SEL_NONE)) ||
                        (m2_request && (m2_slave_select == SEL_NONE)));
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_bus_rr_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_select, m2_slave_select;
    logic       m1_tx_done, m2_tx_done;
    logic       m1_grant, m2_grant, busy, timeout, sel_error;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;

    int tests = 0;
    int fails = 0;

    bus_rr_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .m1_request     (m1_request),
        .m2_request     (m2_request),
        .m1_slave_select(m1_slave_select),
        .m2_slave_select(m2_slave_select),
        .m1_tx_done     (m1_tx_done),
        .m2_tx_done     (m2_tx_done),
        .m1_grant       (m1_grant),
        .m2_grant       (m2_grant),
        .busy           (busy),
        .bus_grant      (bus_grant),
        .slave_grant    (slave_grant),
        .timeout        (timeout),
        .sel_error      (sel_error)
    );

    always #5 clk = ~clk;

    // Output vector layout: {m1_grant, m2_grant, bus_grant, slave_grant, busy, timeout, sel_error}
    localparam logic [9:0] V_IDLE = 10'b0_0_00_000_0_0_0;
    localparam logic [9:0] V_TA   = 10'b0_0_00_000_1_0_0;
    localparam logic [9:0] V_SERR = 10'b0_0_00_000_0_0_1;

    function automatic logic [9:0] outs();
        return {m1_grant, m2_grant, bus_grant, slave_grant, busy, timeout, sel_error};
    endfunction

    function automatic logic [9:0] own_vec(input int owner, input logic [2:0] sg, input logic to);
        return {owner == 1, owner == 2, 2'(owner), sg, 1'b1, to, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr_inputs();
        m1_request = 0; m2_request = 0;
        m1_slave_select = 2'b00; m2_slave_select = 2'b00;
        m1_tx_done = 0; m2_tx_done = 0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        m1_request = 1; m1_slave_select = 2'b01;
        reset = 1;
        tick(); tick();
        settle();
        got = outs(); tests++;
        if (got !== V_IDLE) begin
            fails++; $display("FAIL reset_outputs got=%b exp=%b", got, V_IDLE);
        end
        reset = 0; clr_inputs();
        tick();
    endtask

    task automatic test_single();
        logic [9:0] got, exp;
        m1_request = 1; m1_slave_select = 2'b10;
        settle(); got = outs(); tests++;
        if (got !== V_IDLE) begin fails++; $display("FAIL single_pre got=%b exp=%b", got, V_IDLE); end
        tick();
        for (int i = 1; i <= 5; i++) begin
            m1_tx_done = (i == 5);
            settle(); got = outs(); exp = own_vec(1, 3'b010, 1'b0); tests++;
            if (got !== exp) begin fails++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", i, got, exp); end
            tick();
        end
        m1_tx_done = 0; m1_request = 0;
        settle(); got = outs(); tests++;
        if (got !== V_TA) begin fails++; $display("FAIL single_turnaround got=%b exp=%b", got, V_TA); end
        tick();
        settle(); got = outs(); tests++;
        if (got !== V_IDLE) begin fails++; $display("FAIL single_idle got=%b exp=%b", got, V_IDLE); end
        tick();
    endtask

    task automatic test_alternate();
        logic [9:0] got, exp;
        int owner;
        reset = 1; tick(); reset = 0;
        m1_request = 1; m1_slave_select = 2'b01;
        m2_request = 1; m2_slave_select = 2'b11;
        for (int r = 0; r < 4; r++) begin
            owner = (r % 2 == 0) ? 1 : 2;
            settle(); got = outs(); tests++;
            if (got !== V_IDLE) begin fails++; $display("FAIL alt_idle round=%0d got=%b exp=%b", r, got, V_IDLE); end
            tick();
            for (int k = 1; k <= 3; k++) begin
                m1_tx_done = (owner == 1) ? (k == 3) : (k == 2);
                m2_tx_done = (owner == 2) ? (k == 3) : (k == 2);
                settle();
                got = outs(); exp = own_vec(owner, (owner == 1) ? 3'b001 : 3'b100, 1'b0); tests++;
                if (got !== exp) begin fails++; $display("FAIL alt_owner round=%0d k=%0d got=%b exp=%b", r, k, got, exp); end
                tick();
            end
            m1_tx_done = 0; m2_tx_done = 0;
            settle(); got = outs(); tests++;
            if (got !== V_TA) begin fails++; $display("FAIL alt_turnaround round=%0d got=%b exp=%b", r, got, V_TA); end
            tick();
        end
        clr_inputs();
    endtask

    task automatic test_timeout();
        logic [9:0] got, exp;
        m2_request = 1; m2_slave_select = 2'b10;
        settle(); got = outs(); tests++;
        if (got !== V_IDLE) begin fails++; $display("FAIL to_idle got=%b exp=%b", got, V_IDLE); end
        tick();
        for (int k = 1; k <= TO; k++) begin
            settle(); got = outs(); exp = own_vec(2, 3'b010, k == TO); tests++;
            if (got !== exp) begin fails++; $display("FAIL to_active k=%0d got=%b exp=%b", k, got, exp); end
            tick();
        end
        settle(); got = outs(); tests++;
        if (got !== V_TA) begin fails++; $display("FAIL to_turnaround got=%b exp=%b", got, V_TA); end
        tick();
        settle(); got = outs(); tests++;
        if (got !== V_IDLE) begin fails++; $display("FAIL to_gap got=%b exp=%b", got, V_IDLE); end
        tick();
        settle(); got = outs(); exp = own_vec(2, 3'b010, 1'b0); tests++;
        if (got !== exp) begin fails++; $display("FAIL to_regrant got=%b exp=%b", got, exp); end
        m2_request = 0;
        tick(); tick();
        clr_inputs();
    endtask

    task automatic test_sel_error();
        logic [9:0] got, exp;
        m1_request = 1; m1_slave_select = 2'b00;
        for (int i = 0; i < 2; i++) begin
            settle(); got = outs(); tests++;
            if (got !== V_SERR) begin fails++; $display("FAIL serr_alone i=%0d got=%b exp=%b", i, got, V_SERR); end
            tick();
        end
        m2_request = 1; m2_slave_select = 2'b10;
        for (int r = 0; r < 2; r++) begin
            settle(); got = outs(); tests++;
            if (got !== V_SERR) begin fails++; $display("FAIL serr_idle r=%0d got=%b exp=%b", r, got, V_SERR); end
            tick();
            for (int k = 1; k <= 2; k++) begin
                m2_tx_done = (k == 2);
                settle(); got = outs(); exp = own_vec(2, 3'b010, 1'b0); tests++;
                if (got !== exp) begin fails++; $display("FAIL serr_m2 r=%0d k=%0d got=%b exp=%b", r, k, got, exp); end
                tick();
            end
            m2_tx_done = 0;
            settle(); got = outs(); tests++;
            if (got !== V_TA) begin fails++; $display("FAIL serr_ta r=%0d got=%b exp=%b", r, got, V_TA); end
            tick();
        end
        clr_inputs();
    endtask

    task automatic test_sel_change_reset();
        logic [9:0] got, exp;
        m1_request = 1; m1_slave_select = 2'b01;
        tick();
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) m1_slave_select = 2'b11;
            reset = (k == 3);
            settle(); got = outs(); exp = own_vec(1, 3'b001, 1'b0); tests++;
            if (got !== exp) begin fails++; $display("FAIL chg_latched k=%0d got=%b exp=%b", k, got, exp); end
            tick();
        end
        reset = 0;
        m2_request = 1; m2_slave_select = 2'b10;
        settle(); got = outs(); tests++;
        if (got !== V_IDLE) begin fails++; $display("FAIL chg_after_reset got=%b exp=%b", got, V_IDLE); end
        tick();
        settle(); got = outs(); exp = own_vec(1, 3'b100, 1'b0); tests++;
        if (got !== exp) begin fails++; $display("FAIL chg_first_after_reset got=%b exp=%b", got, exp); end
        clr_inputs();
        tick(); tick();
    endtask

    task automatic test_done_at_tc();
        logic [9:0] got, exp;
        m1_request = 1; m1_slave_select = 2'b01;
        tick();
        for (int k = 1; k <= TO; k++) begin
            m1_tx_done = (k == TO);
            settle(); got = outs(); exp = own_vec(1, 3'b001, 1'b0); tests++;
            if (got !== exp) begin fails++; $display("FAIL tc_done k=%0d got=%b exp=%b", k, got, exp); end
            tick();
        end
        clr_inputs();
        settle(); got = outs(); tests++;
        if (got !== V_TA) begin fails++; $display("FAIL tc_turnaround got=%b exp=%b", got, V_TA); end
        tick(); tick();
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        int phase, owner, last, held, osel, win;
        logic e1, e2, own_req, own_done, rel, e_to, e_se;
        logic [2:0] e_sg;
        reset = 1; tick(); reset = 0;
        phase = 0; owner = 0; last = 2; held = 0; osel = 0;
        for (int n = 0; n < 500; n++) begin
            reset           = ($urandom_range(0, 63) == 0);
            m1_request      = ($urandom_range(0, 3) != 0);
            m2_request      = ($urandom_range(0, 3) != 0);
            m1_slave_select = 2'($urandom_range(0, 3));
            m2_slave_select = 2'($urandom_range(0, 3));
            m1_tx_done      = ($urandom_range(0, 5) == 0);
            m2_tx_done      = ($urandom_range(0, 5) == 0);

            own_req  = (owner == 1) ? m1_request : m2_request;
            own_done = (owner == 1) ? m1_tx_done : m2_tx_done;
            rel      = own_done || !own_req;
            e_to     = !reset && phase == 1 && held == TO - 1 && !rel;
            e_se     = !reset && phase == 0 &&
                       ((m1_request && m1_slave_select == 0) || (m2_request && m2_slave_select == 0));
            e_sg     = (phase == 1) ? (3'b001 << (osel - 1)) : 3'b000;
            if (phase == 1) exp = {owner == 1, owner == 2, 2'(owner), e_sg, 1'b1, e_to, e_se};
            else            exp = {4'b0000, 3'b000, phase != 0, 1'b0, e_se};

            settle(); got = outs(); tests++;
            if (got !== exp) begin
                fails++; $display("FAIL random n=%0d got=%b exp=%b", n, got, exp);
            end

            if (reset) begin
                phase = 0; last = 2; held = 0;
            end else if (phase == 0) begin
                e1 = m1_request && m1_slave_select != 0;
                e2 = m2_request && m2_slave_select != 0;
                win = 0;
                if (e1 && e2)  win = (last == 1) ? 2 : 1;
                else if (e1)   win = 1;
                else if (e2)   win = 2;
                if (win != 0) begin
                    phase = 1; owner = win; last = win; held = 0;
                    osel = (win == 1) ? int'(m1_slave_select) : int'(m2_slave_select);
                end
            end else if (phase == 1) begin
                if (rel || held == TO - 1) phase = 2;
                else held++;
            end else begin
                phase = 0;
            end
            tick();
        end
        reset = 0;
        clr_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout sim time exceeded, stopping");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1;
        clr_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_timeout();
        test_sel_error();
        test_sel_change_reset();
        test_done_at_tc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin bus arbiter for the two-master / three-slave system bus.
- Drives the master-side grants and the `bus_grant`/`slave_grant` selects consumed by `master_mux` and `slave_mux`.
- Adds fairness between the two masters, an explicit one-cycle turnaround between owners, a per-transaction watchdog timeout, and rejection of invalid slave selects.

Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles a master may hold the bus; minimum 2.
- `CNT_W`, default 13: watchdog counter width; must satisfy 2**CNT_W >= `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m1_request`  in  1  master 1 bus request (level).
- `m2_request`  in  1  master 2 bus request (level).
- `m1_slave_select`  in  2  target of master 1: 01=S1, 10=S2, 11=S3, 00=invalid.
- `m2_slave_select`  in  2  target of master 2, same encoding.
- `m1_tx_done`  in  1  master 1 transaction-complete pulse.
- `m2_tx_done`  in  1  master 2 transaction-complete pulse.
- `m1_grant`  out  1  master 1 owns the bus.
- `m2_grant`  out  1  master 2 owns the bus.
- `busy`  out  1  bus owned or in turnaround.
- `bus_grant`  out  2  00=none, 01=M1, 10=M2.
- `slave_grant`  out  3  one-hot slave route: 001=S1, 010=S2, 100=S3, 000=none.
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant.
- `sel_error`  out  1  one-cycle pulse when a request with select 00 is rejected.

Behaviour:
- Reset: state IDLE; `last_owner`=M2, so M1 has first priority. All outputs are 0 and the counter is 0. Reset wins over every other event, including mid-transaction; grants drop in the cycle after reset is sampled.
- States: IDLE, ACTIVE, TURNAROUND.
- IDLE:
  - Requests are evaluated each cycle.
  - Eligible requester = request high AND select != 00.
  - Requester with select 00: `sel_error` pulses once per cycle observed; no grant; state stays IDLE.
  - One eligible requester wins. If both are eligible, the master that is not `last_owner` wins.
  - On a win, go to ACTIVE next cycle. That registered transition asserts the winner's `mX_grant`, `bus_grant`, and `slave_grant` decoded from the winner's select sampled in that cycle.
  - Request-to-grant latency is exactly 1 cycle.
  - `last_owner` updates on entry to ACTIVE.
- ACTIVE:
  - Selects are latched at grant; later changes to `mX_slave_select` are ignored until the next arbitration.
  - The counter increments each cycle.
  - The owner's `tx_done` high, OR the owner's request low, causes a transition to TURNAROUND next cycle.
  - Counter == `TIMEOUT_CYCLES`-1 without release: pulse `timeout` in that cycle, go to TURNAROUND.
  - `tx_done` and timeout in the same cycle: treat as normal completion; no `timeout` pulse.
  - The non-owner's `tx_done` is ignored.
- TURNAROUND:
  - Exactly one cycle.
  - Grants, `bus_grant` and `slave_grant` are 0; `busy`=1; counter cleared.
  - Next state is IDLE, so the earliest regrant comes 2 cycles after release.
- `busy` = (state != IDLE).
- `bus_grant`, `slave_grant` and the `mX_grant` outputs are registered and mutually consistent in every cycle. At most one `mX_grant` is high.
- A master that keeps requesting after release re-arbitrates normally. With both masters continuously requesting, ownership alternates M1, M2, M1, …

Decomposition:
- Shared package `bus_pkg`:
  - state enum (IDLE, ACTIVE, TURNAROUND);
  - `SEL_NONE`/`SEL_S1`/`SEL_S2`/`SEL_S3` codes;
  - `BG_NONE`/`BG_M1`/`BG_M2` codes;
  - one-hot `SG_*` constants.
- One sub-module: `bus_watchdog` (counter with clear, enable and terminal-count pulse, parameterised by `TIMEOUT_CYCLES`/`CNT_W`).
- Select decode and round-robin pick stay inline.

Test Plan:
- Reset then M1 request, sel=10; M1 `tx_done` 5 cycles later:
  - `m1_grant`=1, `bus_grant`=01, `slave_grant`=010 one cycle after request;
  - all grants 0 in the cycle after `tx_done` (TURNAROUND, `busy`=1);
  - `busy`=0 the following cycle.
- Both masters request continuously (M1 sel=01, M2 sel=11), each releasing via `tx_done` after 3 cycles of ownership:
  - grants alternate M1 (`slave_grant` 001), M2 (100), M1 …;
  - first owner after reset is M1;
  - exactly one TURNAROUND cycle between owners.
- `TIMEOUT_CYCLES`=8, M2 holds request with no `tx_done`:
  - `timeout` pulses in the 8th ACTIVE cycle;
  - grant drops next cycle; M2 regranted 2 cycles after release.
- M1 request with sel=00 while M2 requests sel=10:
  - `sel_error`=1 each cycle M1 is sampled in IDLE;
  - M2 granted, `slave_grant`=010; M1 never granted.
- Owner M1 (sel=01) changes select to 11 mid-transaction, then reset asserted:
  - `slave_grant` stays 001 until reset;
  - all outputs 0 the cycle after reset is sampled;
  - next simultaneous request grants M1.
- `tx_done` and watchdog terminal count in the same cycle: `timeout` stays 0; normal TURNAROUND.
